// File: rtl/hub75_pkg.sv
// Shared types, widths and the pixel channel/plane bit extractor for the HUB75 column scanout.
package hub75_pkg;

   localparam int SCAN_RATE_DEF = 32;
   localparam int RGB_RES_DEF   = 9;
   localparam int CH_BITS       = RGB_RES_DEF / 3;
   localparam int ADDR_W        = $clog2(SCAN_RATE_DEF);
   localparam int PLANE_W       = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;
   localparam int PIX_IDX_W     = $clog2(RGB_RES_DEF);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT_LO,
      SHIFT_HI,
      BLANK,
      LATCH,
      DISPLAY
   } state_t;

   typedef enum logic [1:0] {
      CH_R,
      CH_G,
      CH_B
   } channel_t;

   // Pixels are packed {R,G,B}, so R occupies the top CH_BITS and B the bottom.
   function automatic logic chanBit(input logic [RGB_RES_DEF-1:0] pixel,
                                    input channel_t               channel,
                                    input logic [PLANE_W-1:0]     plane);
      logic [PIX_IDX_W-1:0] idx;
      idx = PIX_IDX_W'((2 - int'(channel)) * CH_BITS + int'(plane));
      return pixel[idx];
   endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// Counts the display on-time of one BCM plane: BASE_ON << plane cycles.
module bcm_on_timer #(
   parameter int BASE_ON   = 16,
   parameter int PLANE_W   = 2,
   parameter int MAX_PLANE = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic               i_count,
   input  logic [PLANE_W-1:0] i_plane,
   output logic               o_done
);

   localparam int CNT_W = $clog2((BASE_ON << MAX_PLANE) + 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_loadVal;

   // Loaded with N-1 so that done is high on the N-th counting cycle.
   assign w_loadVal = (CNT_W'(BASE_ON) << i_plane) - CNT_W'(1);
   assign o_done    = (r_cnt == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= w_loadVal;
      end else if (i_count && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/hub75_column_scanout.sv
// Fetches a column pair from the frame generator and scans it onto a 1:32 HUB75 panel
// using 3-plane binary-code modulation.
module hub75_column_scanout
   import hub75_pkg::*;
#(
   parameter int SCAN_RATE = SCAN_RATE_DEF,
   parameter int NUM_COLS  = 2 * SCAN_RATE_DEF,
   parameter int NUM_ROWS  = 64,
   parameter int RGB_RES   = RGB_RES_DEF,
   parameter int BASE_ON   = 16
) (
   input  logic                                     clk_in,
   input  logic                                     rst_n_in,
   input  logic                                     enable_in,
   output logic [ADDR_W-1:0]                        column_index1,
   output logic [ADDR_W:0]                          column_index2,
   input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]    columns_in,
   output logic                                     r0_out,
   output logic                                     g0_out,
   output logic                                     b0_out,
   output logic                                     r1_out,
   output logic                                     g1_out,
   output logic                                     b1_out,
   output logic [ADDR_W-1:0]                        addr_out,
   output logic                                     clk_out,
   output logic                                     lat_out,
   output logic                                     oe_n_out,
   output logic                                     frame_done_out
);

   localparam int PIX_W = $clog2(NUM_ROWS);
   localparam logic [ADDR_W:0] L_IDX2_BASE = (ADDR_W + 1)'(NUM_COLS / 2);

   state_t                              r_state;
   state_t                              w_nextState;
   logic [ADDR_W-1:0]                   r_scan;
   logic [ADDR_W:0]                     r_idx2;
   logic [ADDR_W-1:0]                   r_addr;
   logic [PLANE_W-1:0]                  r_plane;
   logic [PIX_W-1:0]                    r_pix;
   logic                                r_frameDone;
   logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_lineBuf;
   logic                                w_lastPix;
   logic                                w_lastPlane;
   logic                                w_lastLine;
   logic                                w_onDone;
   logic                                w_load;
   logic                                w_count;

   assign w_lastPix   = (r_pix == PIX_W'(NUM_ROWS - 1));
   assign w_lastPlane = (r_plane == PLANE_W'(CH_BITS - 1));
   assign w_lastLine  = (r_scan == ADDR_W'(SCAN_RATE - 1));
   assign w_load      = (r_state == LATCH);
   assign w_count     = (r_state == DISPLAY);

   assign column_index1  = r_scan;
   assign column_index2  = r_idx2;
   assign addr_out       = r_addr;
   assign frame_done_out = r_frameDone;

   bcm_on_timer #(
      .BASE_ON   (BASE_ON),
      .PLANE_W   (PLANE_W),
      .MAX_PLANE (CH_BITS - 1)
   ) u_onTimer (
      .i_clk   (clk_in),
      .i_rst_n (rst_n_in),
      .i_load  (w_load),
      .i_count (w_count),
      .i_plane (r_plane),
      .o_done  (w_onDone)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      oe_n_out    = 1'b1;
      clk_out     = 1'b0;
      lat_out     = 1'b0;
      r0_out      = 1'b0;
      g0_out      = 1'b0;
      b0_out      = 1'b0;
      r1_out      = 1'b0;
      g1_out      = 1'b0;
      b1_out      = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable_in) w_nextState = FETCH;
         end
         FETCH: begin
            w_nextState = SHIFT_LO;
         end
         SHIFT_LO, SHIFT_HI: begin
            r0_out  = chanBit(r_lineBuf[0][r_pix], CH_R, r_plane);
            g0_out  = chanBit(r_lineBuf[0][r_pix], CH_G, r_plane);
            b0_out  = chanBit(r_lineBuf[0][r_pix], CH_B, r_plane);
            r1_out  = chanBit(r_lineBuf[1][r_pix], CH_R, r_plane);
            g1_out  = chanBit(r_lineBuf[1][r_pix], CH_G, r_plane);
            b1_out  = chanBit(r_lineBuf[1][r_pix], CH_B, r_plane);
            clk_out = (r_state == SHIFT_HI);
            if (r_state == SHIFT_LO) begin
               w_nextState = SHIFT_HI;
            end else begin
               w_nextState = w_lastPix ? BLANK : SHIFT_LO;
            end
         end
         BLANK: begin
            w_nextState = LATCH;
         end
         LATCH: begin
            lat_out     = 1'b1;
            w_nextState = DISPLAY;
         end
         DISPLAY: begin
            oe_n_out = 1'b0;
            if (w_onDone) begin
               if (!w_lastPlane) begin
                  w_nextState = SHIFT_LO;
               end else if (w_lastLine && !enable_in) begin
                  w_nextState = IDLE;
               end else begin
                  w_nextState = FETCH;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Higher planes reuse the buffered line; only the last plane advances the scan line.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_scan      <= '0;
         r_idx2      <= '0;
         r_addr      <= '0;
         r_plane     <= '0;
         r_pix       <= '0;
         r_frameDone <= 1'b0;
         r_lineBuf   <= '0;
      end else begin
         r_frameDone <= 1'b0;
         case (r_state)
            IDLE: begin
               r_scan  <= '0;
               r_plane <= '0;
               r_idx2  <= L_IDX2_BASE;
            end
            FETCH: begin
               r_lineBuf <= columns_in;
               r_pix     <= '0;
            end
            SHIFT_HI: begin
               if (!w_lastPix) r_pix <= r_pix + PIX_W'(1);
            end
            BLANK: begin
               r_pix <= '0;
            end
            LATCH: begin
               r_addr <= r_scan;
            end
            DISPLAY: begin
               if (w_onDone) begin
                  if (!w_lastPlane) begin
                     r_plane <= r_plane + PLANE_W'(1);
                  end else begin
                     r_plane <= '0;
                     if (w_lastLine) begin
                        r_scan      <= '0;
                        r_idx2      <= L_IDX2_BASE;
                        r_frameDone <= 1'b1;
                     end else begin
                        r_scan <= r_scan + ADDR_W'(1);
                        r_idx2 <= r_idx2 + (ADDR_W + 1)'(1);
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_column_scanout.sv
// Self-checking bench: a frame-position model predicts every panel output per cycle.
module tb_hub75_column_scanout;

   localparam int LINE_CYC  = 503;
   localparam int FRAME_CYC = 16096;
   localparam int NR        = 64;

   logic                        clk_in = 1'b0;
   logic                        rst_n_in = 1'b0;
   logic                        enable_in = 1'b0;
   logic [4:0]                  column_index1;
   logic [5:0]                  column_index2;
   logic [1:0][NR-1:0][8:0]     columns_in;
   logic                        r0_out, g0_out, b0_out, r1_out, g1_out, b1_out;
   logic [4:0]                  addr_out;
   logic                        clk_out, lat_out, oe_n_out, frame_done_out;

   int nVec = 0;
   int nFail = 0;
   int cyc = 0;
   int patMode = 0;

   logic mRun = 1'b0;
   int   mPos = 0;
   int   mAddr = 0;
   logic mPost = 1'b0;
   logic mDone = 1'b0;

   logic       eOe, eLat, eClk, eDisp;
   logic [5:0] eData;
   int         eLine, ePlane;
   logic [25:0] aVec, eVec;

   int tStart, tDone, t1, t2, t3, n, runLen, k, latCnt, cnt0, addrOk;
   int dispLen [3];

   hub75_column_scanout dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .enable_in      (enable_in),
      .column_index1  (column_index1),
      .column_index2  (column_index2),
      .columns_in     (columns_in),
      .r0_out         (r0_out),
      .g0_out         (g0_out),
      .b0_out         (b0_out),
      .r1_out         (r1_out),
      .g1_out         (g1_out),
      .b1_out         (b1_out),
      .addr_out       (addr_out),
      .clk_out        (clk_out),
      .lat_out        (lat_out),
      .oe_n_out       (oe_n_out),
      .frame_done_out (frame_done_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic logic [8:0] pix(input int mode, input int half, input int idx, input int p);
      int v;
      if (mode == 0) begin
         v = (half == 0) ? 9'b101_010_111 : 9'b000_111_001;
      end else begin
         v = (p * 8 + p / 8 + idx * 5) % 512;
         if (half == 1) v = 511 - v;
      end
      return 9'(v);
   endfunction

   function automatic logic bitOf(input int pixel, input int ch, input int plane);
      int val;
      val = (ch == 0) ? pixel / 64 : (ch == 1) ? (pixel / 8) % 8 : pixel % 8;
      return 1'((val >> plane) & 1);
   endfunction

   // Each line: FETCH, then per plane 128 shift cycles, BLANK, LATCH, 16<<plane display cycles.
   always_comb begin
      int o, q, r, len, pl;
      logic [8:0] up, lo;
      eOe = 1'b1; eLat = 1'b0; eClk = 1'b0; eDisp = 1'b0; eData = 6'b0;
      eLine = 0; ePlane = 0;
      o = 0; q = 0; r = 0; len = 0; pl = 0; up = '0; lo = '0;
      if (mRun) begin
         eLine = mPos / LINE_CYC;
         o = mPos % LINE_CYC;
         if (o > 0) begin
            q = o - 1;
            for (int b = 0; b < 3; b++) begin
               len = 130 + (16 << b);
               if (pl == b && q >= len) begin
                  q = q - len;
                  pl = b + 1;
               end
            end
            ePlane = pl;
            r = q;
            if (r < 128) begin
               eClk = (r % 2 == 1);
               up = pix(patMode, 0, eLine, r / 2);
               lo = pix(patMode, 1, eLine + 32, r / 2);
               eData = {bitOf(int'(up), 0, pl), bitOf(int'(up), 1, pl), bitOf(int'(up), 2, pl),
                        bitOf(int'(lo), 0, pl), bitOf(int'(lo), 1, pl), bitOf(int'(lo), 2, pl)};
            end else if (r == 129) begin
               eLat = 1'b1;
            end else if (r >= 130) begin
               eOe = 1'b0;
               eDisp = 1'b1;
            end
         end
      end
   end

   assign eVec = {eOe, eLat, eClk, mDone, 5'(mAddr), 5'(eLine),
                  (mPost ? 6'(eLine + 32) : 6'd0), eData};
   assign aVec = {oe_n_out, lat_out, clk_out, frame_done_out, addr_out, column_index1,
                  column_index2, r0_out, g0_out, b0_out, r1_out, g1_out, b1_out};

   // Frame-position model: counts cycles since the first FETCH of the frame.
   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mRun  <= 1'b0;
         mPos  <= 0;
         mAddr <= 0;
         mPost <= 1'b0;
         mDone <= 1'b0;
      end else begin
         mPost <= 1'b1;
         mDone <= 1'b0;
         if (!mRun) begin
            if (enable_in) begin
               mRun <= 1'b1;
               mPos <= 0;
            end
         end else begin
            if (eLat) mAddr <= eLine;
            if (mPos == FRAME_CYC - 1) begin
               mDone <= 1'b1;
               mPos  <= 0;
               mRun  <= enable_in;
            end else begin
               mPos <= mPos + 1;
            end
         end
      end
   end

   // Generator stand-in: real data only during FETCH, inverted garbage otherwise.
   initial begin
      logic [8:0] realPix;
      columns_in = '0;
      forever begin
         @(negedge clk_in);
         for (int p = 0; p < NR; p++) begin
            for (int h = 0; h < 2; h++) begin
               realPix = pix(patMode, h, (h == 0) ? int'(column_index1) : int'(column_index2), p);
               columns_in[h][p] = (mRun && (mPos % LINE_CYC == 0)) ? realPix : ~realPix;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_in);
         if (rst_n_in) begin
            nVec++;
            if (aVec !== eVec) begin
               nFail++;
               $display("[TB] FAIL cycle_outputs at cycle %0d: got %h expected %h", cyc, aVec, eVec);
            end
         end
      end
   end

   task automatic applyStimulus(input logic en, input int cycles);
      @(negedge clk_in);
      enable_in = en;
      repeat (cycles) @(negedge clk_in);
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      nVec++;
      if (act != exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic waitDone(input int bound, output int tAt);
      int cnt;
      cnt = 0;
      do begin
         @(negedge clk_in);
         cnt++;
      end while (frame_done_out !== 1'b1 && cnt < bound);
      if (frame_done_out !== 1'b1) checkOutput("frame_done_timeout", 0, 1);
      tAt = cyc;
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      #2 rst_n_in = 1'b1;

      $display("[TB] reset / idle");
      applyStimulus(1'b0, 100);
      checkOutput("idle_oe_n", int'(oe_n_out), 1);
      checkOutput("idle_idx2", int'(column_index2), 32);
      checkOutput("idle_addr", int'(addr_out), 0);

      $display("[TB] single line, constant data");
      patMode = 0;
      applyStimulus(1'b1, 0);
      runLen = 0; k = 0; latCnt = 0; cnt0 = 0; addrOk = 0;
      dispLen[0] = 0; dispLen[1] = 0; dispLen[2] = 0;
      for (int i = 0; i < 505; i++) begin
         @(negedge clk_in);
         if (i == 0) begin
            tStart = cyc;
            enable_in = 1'b0;
         end
         if (oe_n_out == 1'b0) begin
            if (runLen == 0 && addr_out == 5'd0) addrOk++;
            runLen++;
         end else if (runLen > 0) begin
            if (k < 3) dispLen[k] = runLen;
            k++;
            runLen = 0;
         end
         if (lat_out) latCnt++;
         if (clk_out && k == 0 && {r0_out, g0_out, b0_out} == 3'b101 &&
             {r1_out, g1_out, b1_out} == 3'b011) cnt0++;
      end
      checkOutput("display_len_plane0", dispLen[0], 16);
      checkOutput("display_len_plane1", dispLen[1], 32);
      checkOutput("display_len_plane2", dispLen[2], 64);
      checkOutput("latch_pulses", latCnt, 3);
      checkOutput("latch_addr_zero", addrOk, 3);
      checkOutput("plane0_shift_edges", cnt0, 64);
      waitDone(17000, tDone);
      checkOutput("frame_length", tDone - tStart, FRAME_CYC);
      applyStimulus(1'b0, 4);
      checkOutput("post_frame_oe_n", int'(oe_n_out), 1);
      checkOutput("post_frame_idx1", int'(column_index1), 0);

      $display("[TB] continuous frames, ramp data");
      patMode = 1;
      applyStimulus(1'b1, 0);
      waitDone(17000, t1);
      checkOutput("wrap_idx1", int'(column_index1), 0);
      checkOutput("wrap_idx2", int'(column_index2), 32);
      waitDone(17000, t2);
      checkOutput("frame_period", t2 - t1, FRAME_CYC);

      $display("[TB] enable drop at line 10");
      n = 0;
      while (column_index1 != 5'd10 && n < 6000) begin
         @(negedge clk_in);
         n++;
      end
      checkOutput("reach_line10", int'(column_index1), 10);
      enable_in = 1'b0;
      waitDone(17000, t3);
      checkOutput("drop_frame_period", t3 - t2, FRAME_CYC);
      applyStimulus(1'b0, 3);
      checkOutput("drop_idle_oe_n", int'(oe_n_out), 1);

      $display("[TB] async reset in line 5 plane 2 display");
      applyStimulus(1'b1, 0);
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (!(eLine == 5 && ePlane == 2 && eDisp && oe_n_out == 1'b0) && n < 4000);
      checkOutput("reach_line5_plane2", int'(column_index1), 5);
      repeat (10) @(negedge clk_in);
      #2 rst_n_in = 1'b0;
      #1 checkOutput("async_reset_outputs", int'(aVec), 32'h0200_0000);
      repeat (2) @(negedge clk_in);
      #2 rst_n_in = 1'b1;
      repeat (600) @(negedge clk_in);
      checkOutput("restart_idx1", int'(column_index1), 1);
      enable_in = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
